flash_ctrl: RTL and testbench
=============================

FLASH_CTRL -- requirements
Module: flash_ctrl

Interface
REQ-001 The block SHALL have parameter RD_WAIT, default 7, giving the number of cycles fl_oeb is held low per read (range 1..15).
REQ-002 The block SHALL have parameter WR_WAIT, default 7, giving the number of cycles fl_web is held low per write (range 1..15).
REQ-003 The block SHALL have parameter RECOVERY, default 2, giving the number of fl_ceb-high cycles after each access (range 1..15).
REQ-004 The block SHALL have these ports:
- wb_clk_i  in  1  single clock; all logic on its rising edge.
- wb_rst_ni  in  1  synchronous, active-low reset.
- wb_adr_i  in  32  byte address; bits [21:2] form the flash word address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data.
- wb_sel_i  in  4  byte selects; ignored.
- wb_we_i  in  1  write request.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_ack_o  out  1  access done.
- wb_err_o  out  1  access rejected.
- fl_addr  out  20  flash address, shared by both 16-bit devices.
- fl_dq_o  out  32  data toward flash.
- fl_dq_oe  out  1  drive enable for fl_dq_o; the top-level tristates the 32-bit dq bus with it.
- fl_dq_i  in  32  data from flash.
- fl_ceb, fl_oeb, fl_web  out  1 each  active-low chip, output and write enables.
- fl_rpb  out  1  active-low flash reset/powerdown.
- fl_wpb  out  1  active-low write protect.

Function
REQ-005 States SHALL be IDLE, SETUP, READ, WRITE, ACK, RECOVER.
REQ-006 In IDLE, wb_cyc_i&wb_stb_i SHALL latch wb_adr_i[21:2] into fl_addr and wb_dat_i into the write register, then move to SETUP.
REQ-007 SETUP SHALL last one cycle with fl_ceb=0 and fl_oeb=fl_web=1, then move to READ if wb_we_i=0 or to WRITE if wb_we_i=1.
REQ-008 READ SHALL hold fl_ceb=0 and fl_oeb=0 for RD_WAIT cycles, and SHALL register fl_dq_i into wb_dat_o on its last cycle.
REQ-009 WRITE SHALL hold fl_ceb=0, fl_web=0 and fl_dq_oe=1 for WR_WAIT cycles.
REQ-010 fl_dq_oe SHALL stay high for one cycle after fl_web rises, giving data hold.
REQ-011 ACK SHALL last one cycle with fl_ceb=fl_oeb=fl_web=1 and wb_ack_o=1, then move to RECOVER.
REQ-012 Read timing: with the request first sampled in IDLE in cycle 0, wb_ack_o SHALL be high in cycle RD_WAIT+2, and only in that cycle.
REQ-013 Write timing: under the same convention, wb_ack_o SHALL be high in cycle WR_WAIT+2.
REQ-014 RECOVER SHALL hold fl_ceb=1 for RECOVERY cycles and then return to IDLE; new requests SHALL NOT be accepted during RECOVER.
REQ-015 wb_dat_o SHALL hold its value until the next read completes.
REQ-016 A write SHALL drive all 32 bits regardless of wb_sel_i, so both devices receive the same command cycle.
REQ-017 Abort: if wb_cyc_i drops after acceptance, the flash cycle SHALL still complete with full timing, and wb_ack_o SHALL be suppressed.
REQ-018 Address counters SHALL be 4 bits wide, count down, and need no wrap handling; fl_addr SHALL change only in IDLE.
REQ-019 wb_ack_o and wb_err_o SHALL never be high in the same cycle.

Reset
REQ-020 While wb_rst_ni=0, at each clock edge the following SHALL hold:
- state = IDLE.
- fl_ceb = fl_oeb = fl_web = 1.
- fl_dq_oe = 0.
- fl_addr = 0; wb_dat_o = 0.
- wb_ack_o = wb_err_o = 0.
- fl_rpb = 0.
REQ-021 fl_rpb SHALL go to 1 on the first edge after wb_rst_ni returns high.
REQ-022 A reset asserted during any access SHALL abort it at the next edge, with no ack and no further flash strobes.

Configuration
REQ-023 With FLASH_CTRL_WRITE_EN defined:
- the WRITE path is present.
- fl_wpb = 1 after reset.
REQ-024 Without FLASH_CTRL_WRITE_EN:
- the WRITE state is absent.
- fl_web = 1 and fl_dq_oe = 0 permanently; fl_wpb = 0.
- a request with wb_we_i=1 goes IDLE -> ACK-timed error: wb_err_o high for one cycle, in cycle 1 after acceptance, with no flash strobes, then RECOVER.

Verification
REQ-025 Read: default parameters, read 0x0000_0010 with flash word 4 = 0xCAFE_BABE -> fl_addr=4, fl_oeb low in cycles 2-8, ack in cycle 9, wb_dat_o=0xCAFEBABE.
REQ-026 Back-to-back: two reads with stb held high -> second SETUP starts exactly RECOVERY+1 cycles after the first ack; fl_ceb high for 2 cycles in between.
REQ-027 Write (WRITE_EN defined): write 0x0040_0040 to 0x0 -> fl_web low in cycles 2-8, fl_dq_oe high in cycles 2-9, dq=0x00400040, ack in cycle 9.
REQ-028 Write with WRITE_EN undefined -> wb_err_o in cycle 1; fl_web, fl_oeb and fl_ceb stay 1 throughout.
REQ-029 Reset mid-read: wb_rst_ni low in cycle 4 -> in cycle 5, fl_ceb=1, fl_oeb=1, fl_rpb=0, no ack; fl_rpb=1 one cycle after release.
REQ-030 Abort: wb_cyc_i dropped in cycle 3 of a read -> fl_oeb still low through cycle 8; wb_ack_o never asserts.

Source files
------------

// File: rtl/flash_ctrl.sv
// Wishbone-to-parallel-NOR bridge for two 16-bit flash devices sharing one address bus.
// Optional write path enabled by defining FLASH_CTRL_WRITE_EN; otherwise writes are rejected with wb_err_o.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for cyc&stb; address/data latched on acceptance
// SETUP   | one cycle of fl_ceb low before the strobe
// READ    | fl_oeb low for RD_WAIT cycles, data captured on the last one
// WRITE   | fl_web low with dq driven for WR_WAIT cycles
// ACK     | one cycle, strobes released, ack (or error) to the bus
// RECOVER | fl_ceb high; together with the following IDLE cycle this gives RECOVERY cycles

module flash_ctrl #(
    parameter int unsigned RD_WAIT  = 7,
    parameter int unsigned WR_WAIT  = 7,
    parameter int unsigned RECOVERY = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic [19:0] fl_addr,
    output logic [31:0] fl_dq_o,
    output logic        fl_dq_oe,
    input  logic [31:0] fl_dq_i,
    output logic        fl_ceb,
    output logic        fl_oeb,
    output logic        fl_web,
    output logic        fl_rpb,
    output logic        fl_wpb
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        READ,
        ACK,
        RECOVER
`ifdef FLASH_CTRL_WRITE_EN
        , WRITE
`endif
    } state_t;

    localparam logic [3:0] RD_TC  = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_TC  = 4'(WR_WAIT - 1);
    localparam logic [3:0] REC_TC = (RECOVERY > 1) ? 4'(RECOVERY - 2) : 4'd0;

    state_t      state, state_nx;
    logic [3:0]  cnt, cnt_nx;
    logic [19:0] addr_q;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        is_wr;
    logic        aborted;
    logic        rpb_q;
    logic        req;

    assign req = wb_cyc_i & wb_stb_i;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            addr_q  <= 20'd0;
            wr_data <= 32'd0;
            rd_data <= 32'd0;
            is_wr   <= 1'b0;
            aborted <= 1'b0;
            rpb_q   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            rpb_q <= 1'b1;
            if (state == IDLE && req) begin
                addr_q  <= wb_adr_i[21:2];
`ifdef FLASH_CTRL_WRITE_EN
                wr_data <= wb_dat_i;
`endif
                is_wr   <= wb_we_i;
                aborted <= 1'b0;
            end else if (state != IDLE && !wb_cyc_i) begin
                // sticky: the flash cycle runs to completion but the bus is never acked
                aborted <= 1'b1;
            end
            if (state == READ && cnt == 4'd0) begin
                rd_data <= fl_dq_i;
            end
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        fl_ceb   = 1'b1;
        fl_oeb   = 1'b1;
        fl_web   = 1'b1;
        fl_dq_oe = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
`ifdef FLASH_CTRL_WRITE_EN
                    state_nx = SETUP;
`else
                    state_nx = wb_we_i ? ACK : SETUP;
`endif
                end
            end
            SETUP: begin
                fl_ceb = 1'b0;
`ifdef FLASH_CTRL_WRITE_EN
                if (is_wr) begin
                    state_nx = WRITE;
                    cnt_nx   = WR_TC;
                end else begin
                    state_nx = READ;
                    cnt_nx   = RD_TC;
                end
`else
                state_nx = READ;
                cnt_nx   = RD_TC;
`endif
            end
            READ: begin
                fl_ceb = 1'b0;
                fl_oeb = 1'b0;
                if (cnt == 4'd0) state_nx = ACK;
                else             cnt_nx   = cnt - 4'd1;
            end
`ifdef FLASH_CTRL_WRITE_EN
            WRITE: begin
                fl_ceb   = 1'b0;
                fl_web   = 1'b0;
                fl_dq_oe = 1'b1;
                if (cnt == 4'd0) state_nx = ACK;
                else             cnt_nx   = cnt - 4'd1;
            end
`endif
            ACK: begin
`ifdef FLASH_CTRL_WRITE_EN
                fl_dq_oe = is_wr;
`endif
                if (RECOVERY > 1) begin
                    state_nx = RECOVER;
                    cnt_nx   = REC_TC;
                end else begin
                    state_nx = IDLE;
                end
            end
            RECOVER: begin
                if (cnt == 4'd0) state_nx = IDLE;
                else             cnt_nx   = cnt - 4'd1;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef FLASH_CTRL_WRITE_EN
    assign wb_ack_o = (state == ACK) & ~aborted & wb_cyc_i;
    assign wb_err_o = 1'b0;
    assign fl_wpb   = rpb_q;
    logic unused_in;
    assign unused_in = ^{wb_sel_i, wb_adr_i[31:22], wb_adr_i[1:0]};
`else
    assign wb_ack_o = (state == ACK) & ~is_wr & ~aborted & wb_cyc_i;
    assign wb_err_o = (state == ACK) &  is_wr & ~aborted & wb_cyc_i;
    assign fl_wpb   = 1'b0;
    logic unused_in;
    assign unused_in = ^{wb_sel_i, wb_adr_i[31:22], wb_adr_i[1:0], wb_dat_i};
`endif

    assign wb_dat_o = rd_data;
    assign fl_addr  = addr_q;
    assign fl_dq_o  = wr_data;
    assign fl_rpb   = rpb_q;

endmodule

// File: tb/tb_flash_ctrl.sv
// Self-checking bench for flash_ctrl: cycle-accurate strobe timing plus a read-data scoreboard.
// Builds against either configuration of FLASH_CTRL_WRITE_EN.
module tb_flash_ctrl;
    localparam int RD_WAIT  = 7;
    localparam int WR_WAIT  = 7;
    localparam int RECOVERY = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] adr, dat, wb_dat_o;
    logic [3:0]  sel;
    logic        we, cyc, stb, wb_ack_o, wb_err_o;
    logic [19:0] fl_addr;
    logic [31:0] fl_dq_o, fl_dq_i;
    logic        fl_dq_oe, fl_ceb, fl_oeb, fl_web, fl_rpb, fl_wpb;

    logic [31:0] mem [16];
    logic [31:0] exp_q [$];
    logic [31:0] last_rd;
    logic [31:0] exp_d;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // flash model: data is only valid while the output enable is asserted
    assign fl_dq_i = fl_oeb ? 32'hDEAD_0000 : mem[fl_addr[3:0]];

    flash_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .RECOVERY(RECOVERY)) dut (
        .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_adr_i(adr), .wb_dat_i(dat),
        .wb_dat_o(wb_dat_o), .wb_sel_i(sel), .wb_we_i(we), .wb_cyc_i(cyc),
        .wb_stb_i(stb), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .fl_addr(fl_addr), .fl_dq_o(fl_dq_o), .fl_dq_oe(fl_dq_oe), .fl_dq_i(fl_dq_i),
        .fl_ceb(fl_ceb), .fl_oeb(fl_oeb), .fl_web(fl_web), .fl_rpb(fl_rpb), .fl_wpb(fl_wpb)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic wpb_exp;
`ifdef FLASH_CTRL_WRITE_EN
        wpb_exp = 1'b1;
`else
        wpb_exp = 1'b0;
`endif
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;
        repeat (3) begin
            @(negedge clk);
            checks++; if ({fl_ceb, fl_oeb, fl_web} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b exp 111", {fl_ceb, fl_oeb, fl_web}); end
            checks++; if (fl_dq_oe !== 1'b0) begin errors++; $display("FAIL reset_dq_oe: got %b exp 0", fl_dq_oe); end
            checks++; if (fl_addr !== 20'd0) begin errors++; $display("FAIL reset_addr: got %h exp 0", fl_addr); end
            checks++; if (wb_dat_o !== 32'd0) begin errors++; $display("FAIL reset_dat: got %h exp 0", wb_dat_o); end
            checks++; if ({wb_ack_o, wb_err_o} !== 2'b00) begin errors++; $display("FAIL reset_ack_err: got %b exp 00", {wb_ack_o, wb_err_o}); end
            checks++; if (fl_rpb !== 1'b0) begin errors++; $display("FAIL reset_rpb: got %b exp 0", fl_rpb); end
            checks++; if (fl_wpb !== 1'b0) begin errors++; $display("FAIL reset_wpb: got %b exp 0", fl_wpb); end
        end
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (fl_rpb !== 1'b0) begin errors++; $display("FAIL rpb_before_edge: got %b exp 0", fl_rpb); end
        @(negedge clk);
        checks++; if (fl_rpb !== 1'b1) begin errors++; $display("FAIL rpb_after_release: got %b exp 1", fl_rpb); end
        checks++; if (fl_wpb !== wpb_exp) begin errors++; $display("FAIL wpb_after_release: got %b exp %b", fl_wpb, wpb_exp); end
        tick();
    endtask

    task automatic test_read();
        bit drop = 0;
        adr = 32'h0000_0010; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        exp_q.push_back(mem[4]);
        for (int c = 0; c < 14; c++) begin
            if (drop) begin cyc = 1'b0; stb = 1'b0; end
            @(negedge clk);
            checks++; if (fl_oeb !== !(c >= 2 && c <= RD_WAIT + 1)) begin errors++; $display("FAIL read_oeb c%0d: got %b", c, fl_oeb); end
            checks++; if (wb_ack_o !== (c == RD_WAIT + 2)) begin errors++; $display("FAIL read_ack c%0d: got %b", c, wb_ack_o); end
            checks++; if (fl_web !== 1'b1 || fl_dq_oe !== 1'b0 || wb_err_o !== 1'b0) begin errors++; $display("FAIL read_quiet c%0d: web %b oe %b err %b", c, fl_web, fl_dq_oe, wb_err_o); end
            if (c >= 1 && c <= RD_WAIT + 1) begin
                checks++; if (fl_ceb !== 1'b0 || fl_addr !== 20'd4) begin errors++; $display("FAIL read_ceb_addr c%0d: ceb %b addr %h exp 0/4", c, fl_ceb, fl_addr); end
            end
            if (wb_ack_o) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL read_sb: unexpected ack, got %h", wb_dat_o); end
                else begin
                    exp_d = exp_q.pop_front();
                    if (wb_dat_o !== exp_d) begin errors++; $display("FAIL read_data: got %h exp %h", wb_dat_o, exp_d); end
                    last_rd = exp_d;
                end
                drop = 1;
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        int ack1 = -1, setup2 = -1, ceb_hi = 0, nacks = 0;
        bit drop = 0;
        adr = 32'h0000_0014; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        exp_q.push_back(mem[5]);
        for (int c = 0; c < 26; c++) begin
            if (c == 10) begin adr = 32'h0000_0018; exp_q.push_back(mem[6]); end
            if (drop) begin cyc = 1'b0; stb = 1'b0; end
            @(negedge clk);
            checks++; if (wb_ack_o && wb_err_o) begin errors++; $display("FAIL b2b_ack_err c%0d: both high", c); end
            if (ack1 >= 0 && setup2 < 0 && c > ack1) begin
                if (!fl_ceb) begin
                    setup2 = c;
                    checks++; if (fl_oeb !== 1'b1) begin errors++; $display("FAIL b2b_setup_oeb: got %b exp 1", fl_oeb); end
                end else ceb_hi++;
            end
            if (wb_ack_o) begin
                nacks++;
                if (ack1 < 0) ack1 = c;
                if (nacks == 2) drop = 1;
                checks++;
                if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_sb: unexpected ack, got %h", wb_dat_o); end
                else begin
                    exp_d = exp_q.pop_front();
                    if (wb_dat_o !== exp_d) begin errors++; $display("FAIL b2b_data: got %h exp %h", wb_dat_o, exp_d); end
                    last_rd = exp_d;
                end
            end
            tick();
        end
        checks++; if (nacks != 2) begin errors++; $display("FAIL b2b_nacks: got %0d exp 2", nacks); end
        checks++; if (setup2 - ack1 != RECOVERY + 1) begin errors++; $display("FAIL b2b_gap: got %0d exp %0d", setup2 - ack1, RECOVERY + 1); end
        checks++; if (ceb_hi != RECOVERY) begin errors++; $display("FAIL b2b_ceb_high: got %0d exp %0d", ceb_hi, RECOVERY); end
    endtask

`ifdef FLASH_CTRL_WRITE_EN
    task automatic test_write();
        bit drop = 0;
        adr = 32'h0; dat = 32'h0040_0040; sel = 4'b0001; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c < 14; c++) begin
            if (drop) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
            @(negedge clk);
            checks++; if (fl_web !== !(c >= 2 && c <= WR_WAIT + 1)) begin errors++; $display("FAIL wr_web c%0d: got %b", c, fl_web); end
            checks++; if (fl_dq_oe !== (c >= 2 && c <= WR_WAIT + 2)) begin errors++; $display("FAIL wr_dq_oe c%0d: got %b", c, fl_dq_oe); end
            checks++; if (wb_ack_o !== (c == WR_WAIT + 2)) begin errors++; $display("FAIL wr_ack c%0d: got %b", c, wb_ack_o); end
            checks++; if (fl_oeb !== 1'b1 || wb_err_o !== 1'b0) begin errors++; $display("FAIL wr_quiet c%0d: oeb %b err %b", c, fl_oeb, wb_err_o); end
            if (fl_dq_oe) begin
                checks++; if (fl_dq_o !== 32'h0040_0040 || fl_addr !== 20'd0) begin errors++; $display("FAIL wr_bus c%0d: dq %h addr %h exp 00400040/0", c, fl_dq_o, fl_addr); end
            end
            if (wb_ack_o) drop = 1;
            tick();
        end
        sel = 4'b0;
        checks++; if (wb_dat_o !== last_rd) begin errors++; $display("FAIL wr_dat_hold: got %h exp %h", wb_dat_o, last_rd); end
    endtask
`else
    task automatic test_write_err();
        adr = 32'h0000_001C; dat = 32'h1234_5678; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 2) begin cyc = 1'b0; stb = 1'b0; we = 1'b0; end
            @(negedge clk);
            checks++; if (wb_err_o !== (c == 1)) begin errors++; $display("FAIL err_pulse c%0d: got %b", c, wb_err_o); end
            checks++; if ({fl_ceb, fl_oeb, fl_web} !== 3'b111) begin errors++; $display("FAIL err_strobes c%0d: got %b exp 111", c, {fl_ceb, fl_oeb, fl_web}); end
            checks++; if (fl_dq_oe !== 1'b0 || wb_ack_o !== 1'b0) begin errors++; $display("FAIL err_quiet c%0d: oe %b ack %b", c, fl_dq_oe, wb_ack_o); end
            tick();
        end
        checks++; if (wb_dat_o !== last_rd) begin errors++; $display("FAIL err_dat_hold: got %h exp %h", wb_dat_o, last_rd); end
    endtask
`endif

    task automatic test_abort();
        adr = 32'h0000_0020; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c < 15; c++) begin
            if (c == 3) begin cyc = 1'b0; stb = 1'b0; end
            if (c == 6) cyc = 1'b1;
            if (c == 12) cyc = 1'b0;
            @(negedge clk);
            checks++; if (fl_oeb !== !(c >= 2 && c <= RD_WAIT + 1)) begin errors++; $display("FAIL abort_oeb c%0d: got %b", c, fl_oeb); end
            checks++; if (wb_ack_o !== 1'b0 || wb_err_o !== 1'b0) begin errors++; $display("FAIL abort_ack c%0d: ack %b err %b exp 0", c, wb_ack_o, wb_err_o); end
            tick();
        end
    endtask

    task automatic test_reset_mid_read();
        adr = 32'h0000_0024; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        for (int c = 0; c < 13; c++) begin
            if (c == 4) begin rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; end
            if (c == 5) rst_n = 1'b1;
            @(negedge clk);
            checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL rst_ack c%0d: got %b exp 0", c, wb_ack_o); end
            if (c == 2 || c == 3) begin
                checks++; if (fl_oeb !== 1'b0) begin errors++; $display("FAIL rst_pre_oeb c%0d: got %b exp 0", c, fl_oeb); end
            end
            if (c >= 5) begin
                checks++; if (fl_ceb !== 1'b1 || fl_oeb !== 1'b1) begin errors++; $display("FAIL rst_strobes c%0d: ceb %b oeb %b exp 1/1", c, fl_ceb, fl_oeb); end
            end
            if (c == 5) begin
                checks++; if (fl_rpb !== 1'b0) begin errors++; $display("FAIL rst_rpb_low: got %b exp 0", fl_rpb); end
                checks++; if (fl_addr !== 20'd0 || wb_dat_o !== 32'd0) begin errors++; $display("FAIL rst_regs: addr %h dat %h exp 0/0", fl_addr, wb_dat_o); end
            end
            if (c >= 6) begin
                checks++; if (fl_rpb !== 1'b1) begin errors++; $display("FAIL rst_rpb_high c%0d: got %b exp 1", c, fl_rpb); end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
        mem[4] = 32'hCAFE_BABE;
        mem[5] = 32'h5A5A_A5A5;
        mem[6] = 32'h0123_4567;
        last_rd = 32'd0;
        test_reset();
        test_read();
        test_back_to_back();
`ifdef FLASH_CTRL_WRITE_EN
        test_write();
`else
        test_write_err();
`endif
        test_abort();
        test_reset_mid_read();
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d exp 0", exp_q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
